// File: rtl/heartbeat_pkg.sv
// rtl/heartbeat_pkg.sv - shared state enum, LED patterns and default timing for the heartbeat sequencer
package heartbeat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT1,
    ST_GAP,
    ST_BEAT2,
    ST_REST
  } hb_state_e;

  localparam logic [9:0] PAT_BEAT1 = 10'b1111111111;
  localparam logic [9:0] PAT_BEAT2 = 10'b0011111100;
  localparam logic [9:0] PAT_OFF   = 10'b0000000000;

  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_BEAT_TICKS = 100;
  localparam int DEF_GAP_TICKS  = 150;
  localparam int DEF_REST0      = 1000;
  localparam int DEF_REST1      = 700;
  localparam int DEF_REST2      = 450;
  localparam int DEF_REST3      = 250;

  function automatic logic [9:0] led_pattern(input hb_state_e s);
    case (s)
      ST_BEAT1: led_pattern = PAT_BEAT1;
      ST_BEAT2: led_pattern = PAT_BEAT2;
      default:  led_pattern = PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the clock into a one-cycle tick every TICK_DIV cycles
module tick_prescaler #(
  parameter int TICK_DIV = heartbeat_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/heartbeat_sequencer.sv
// rtl/heartbeat_sequencer.sv - two-beat LED heartbeat with a four-step selectable rest interval
module heartbeat_sequencer
  import heartbeat_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int BEAT_TICKS = DEF_BEAT_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int REST0      = DEF_REST0,
  parameter int REST1      = DEF_REST1,
  parameter int REST2      = DEF_REST2,
  parameter int REST3      = DEF_REST3
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       enable,
  input  logic       rate_step,
  output logic [9:0] LEDR,
  output logic       beat_pulse,
  output logic [1:0] rate
);

  localparam logic [10:0] BEAT_LEN = 11'(BEAT_TICKS);
  localparam logic [10:0] GAP_LEN  = 11'(GAP_TICKS);
  localparam logic [10:0] REST0_LEN = 11'(REST0);
  localparam logic [10:0] REST1_LEN = 11'(REST1);
  localparam logic [10:0] REST2_LEN = 11'(REST2);
  localparam logic [10:0] REST3_LEN = 11'(REST3);

  hb_state_e   state, state_next;
  logic [10:0] phase;
  logic [10:0] rest_len;
  logic [10:0] rest_sel;
  logic [10:0] cur_len;
  logic        tick;
  logic        phase_done;
  logic        counter_clear;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (CLOCK_50),
    .reset(RESET),
    .clear(counter_clear),
    .tick (tick)
  );

  always_comb begin
    rest_sel = REST0_LEN;
    case (rate)
      2'd0: rest_sel = REST0_LEN;
      2'd1: rest_sel = REST1_LEN;
      2'd2: rest_sel = REST2_LEN;
      2'd3: rest_sel = REST3_LEN;
      default: rest_sel = REST0_LEN;
    endcase
  end

  always_comb begin
    state_next = state;
    cur_len    = BEAT_LEN;
    case (state)
      ST_GAP:  cur_len = GAP_LEN;
      ST_REST: cur_len = rest_len;
      default: cur_len = BEAT_LEN;
    endcase
    phase_done = tick && (phase == cur_len - 11'd1);

    if (state == ST_IDLE) begin
      if (enable) state_next = ST_BEAT1;
    end else if (!enable) begin
      state_next = ST_IDLE;
    end else if (phase_done) begin
      case (state)
        ST_BEAT1: state_next = ST_GAP;
        ST_GAP:   state_next = ST_BEAT2;
        ST_BEAT2: state_next = ST_REST;
        ST_REST:  state_next = ST_BEAT1;
        default:  state_next = ST_IDLE;
      endcase
    end

    // Holding the counters clear in IDLE makes every first state start from a clean tick.
    counter_clear = (state_next != state) || (state == ST_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= ST_IDLE;
      phase      <= '0;
      rate       <= '0;
      rest_len   <= REST0_LEN;
      LEDR       <= PAT_OFF;
      beat_pulse <= 1'b0;
    end else begin
      state <= state_next;
      if (counter_clear) begin
        phase <= '0;
      end else if (tick) begin
        phase <= phase + 11'd1;
      end
      rate <= rate + {1'b0, rate_step};
      // Latched only on entry so a rate change mid-REST waits for the next REST.
      if (state_next == ST_REST && state != ST_REST) begin
        rest_len <= rest_sel;
      end
      LEDR       <= led_pattern(state_next);
      beat_pulse <= (state_next == ST_BEAT1) && (state != ST_BEAT1);
    end
  end

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// tb/tb_heartbeat_sequencer.sv - directed self-checking bench for heartbeat_sequencer
module tb_heartbeat_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rate_step;
  logic [9:0] ledr;
  logic       beat_pulse;
  logic [1:0] rate;

  int total = 0;
  int bad   = 0;

  heartbeat_sequencer #(
    .TICK_DIV  (4),
    .BEAT_TICKS(2),
    .GAP_TICKS (2),
    .REST0     (10),
    .REST1     (8),
    .REST2     (6),
    .REST3     (4)
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (reset),
    .enable    (enable),
    .rate_step (rate_step),
    .LEDR      (ledr),
    .beat_pulse(beat_pulse),
    .rate      (rate)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_for_led(input logic [9:0] val, input int max, output bit ok);
    int n;
    n = 0;
    while (ledr !== val && n < max) begin
      step();
      n++;
    end
    ok = (ledr === val);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_led: LEDR=%h never reached %h within %0d cycles", ledr, val, max);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rate_step = 1'b0;
    repeat (3) step();
    total++;
    if (ledr !== 10'h000 || beat_pulse !== 1'b0 || rate !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold: LEDR=%h pulse=%b rate=%0d, want 000/0/0", ledr, beat_pulse, rate);
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if (ledr !== 10'h000 || beat_pulse !== 1'b0 || rate !== 2'd0) begin
        bad++;
        $display("FAIL idle_%0d: LEDR=%h pulse=%b rate=%0d, want 000/0/0", i, ledr, beat_pulse, rate);
      end
    end
  endtask

  task automatic test_beat_sequence();
    logic [9:0] exp_led;
    int pos;
    enable = 1'b1;
    for (int k = 0; k < 128; k++) begin
      step();
      pos = k % 64;
      if (pos < 8)       exp_led = 10'h3FF;
      else if (pos < 16) exp_led = 10'h000;
      else if (pos < 24) exp_led = 10'h0FC;
      else               exp_led = 10'h000;
      total++;
      if (ledr !== exp_led || beat_pulse !== (pos == 0)) begin
        bad++;
        $display("FAIL beat_seq_%0d: LEDR=%h pulse=%b, want %h/%b", k, ledr, beat_pulse, exp_led, pos == 0);
      end
    end
  endtask

  task automatic test_rate_step();
    logic [1:0] exp_rate;
    exp_rate = 2'd0;
    for (int i = 0; i < 4; i++) begin
      rate_step = 1'b1;
      step();
      exp_rate = exp_rate + 2'd1;
      total++;
      if (rate !== exp_rate) begin
        bad++;
        $display("FAIL rate_step_%0d: rate=%0d, want %0d", i, rate, exp_rate);
      end
      rate_step = 1'b0;
      step();
    end
  endtask

  task automatic test_rest_latch();
    bit ok;
    int rest_cnt;
    int n;
    int period;
    int off_cnt;
    wait_for_led(10'h0FC, 200, ok);
    wait_for_led(10'h000, 20, ok);
    rest_cnt = 0;
    n = 0;
    while (beat_pulse !== 1'b1 && n < 200) begin
      rest_cnt++;
      rate_step = (n == 5);
      step();
      n++;
    end
    rate_step = 1'b0;
    total++;
    if (rest_cnt !== 40) begin
      bad++;
      $display("FAIL rest_current: REST lasted %0d cycles, want 40", rest_cnt);
    end
    total++;
    if (rate !== 2'd1) begin
      bad++;
      $display("FAIL rate_mid_rest: rate=%0d, want 1", rate);
    end
    period = 0;
    off_cnt = 0;
    do begin
      step();
      period++;
      if (ledr === 10'h000) off_cnt++;
    end while (beat_pulse !== 1'b1 && period < 200);
    total++;
    if (period !== 56) begin
      bad++;
      $display("FAIL period_rate1: period=%0d cycles, want 56", period);
    end
    total++;
    if (off_cnt !== 40) begin
      bad++;
      $display("FAIL off_rate1: dark cycles=%0d, want 40 (gap 8 + rest 32)", off_cnt);
    end
  endtask

  task automatic test_disable();
    bit ok;
    wait_for_led(10'h0FC, 200, ok);
    step();
    enable = 1'b0;
    rate_step = 1'b1;
    step();
    total++;
    if (ledr !== 10'h000 || beat_pulse !== 1'b0 || rate !== 2'd2) begin
      bad++;
      $display("FAIL disable: LEDR=%h pulse=%b rate=%0d, want 000/0/2", ledr, beat_pulse, rate);
    end
    repeat (2) step();
    rate_step = 1'b0;
    total++;
    if (rate !== 2'd0) begin
      bad++;
      $display("FAIL rate_held: rate=%0d, want 0", rate);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (ledr !== 10'h000 || beat_pulse !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_disable_%0d: LEDR=%h pulse=%b, want 000/0", i, ledr, beat_pulse);
      end
    end
    enable = 1'b1;
    step();
    total++;
    if (ledr !== 10'h3FF || beat_pulse !== 1'b1) begin
      bad++;
      $display("FAIL reenable: LEDR=%h pulse=%b, want 3ff/1", ledr, beat_pulse);
    end
    step();
    total++;
    if (ledr !== 10'h3FF || beat_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reenable_pulse_len: LEDR=%h pulse=%b, want 3ff/0", ledr, beat_pulse);
    end
  endtask

  task automatic test_reset_mid_beat();
    int period;
    step();
    reset = 1'b1;
    rate_step = 1'b1;
    enable = 1'b1;
    step();
    total++;
    if (ledr !== 10'h000 || beat_pulse !== 1'b0 || rate !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_beat: LEDR=%h pulse=%b rate=%0d, want 000/0/0", ledr, beat_pulse, rate);
    end
    reset = 1'b0;
    rate_step = 1'b0;
    step();
    total++;
    if (ledr !== 10'h3FF || beat_pulse !== 1'b1 || rate !== 2'd0) begin
      bad++;
      $display("FAIL restart_after_reset: LEDR=%h pulse=%b rate=%0d, want 3ff/1/0", ledr, beat_pulse, rate);
    end
    period = 0;
    do begin
      step();
      period++;
    end while (beat_pulse !== 1'b1 && period < 200);
    total++;
    if (period !== 64) begin
      bad++;
      $display("FAIL period_after_reset: period=%0d cycles, want 64", period);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    rate_step = 1'b0;
    test_reset();
    test_beat_sequence();
    test_rate_step();
    test_rest_latch();
    test_disable();
    test_reset_mid_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
